parking_gate_arbiter: RTL and testbench

Arbitrates up to NUM_GATES physical gate stations (entry or exit, university or general car) onto the single shared occupancy counter of the parking controller. It serializes one car event at a time and checks the counter's vacancy and occupancy flags. It issues the one-cycle `car_entered` / `car_exited` / `is_uni` strobes the counter consumes, acknowledges the requesting gate, and times that gate's barrier opening.

---
 rtl/parking_gate_arbiter.sv | 153 +++++++++++++++
 tb/tb_parking_gate_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_arbiter.sv
// Serializes gate-station car events onto the shared occupancy counter, acks the gate and times its barrier.
// Optional PARKING_EXIT_PRIORITY_EN: exits are arbitrated ahead of entries (round-robin within each class).
module parking_gate_arbiter #(
   parameter int NUM_GATES   = 4,
   parameter int OPEN_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_GATES-1:0] gate_req,
   input  logic [NUM_GATES-1:0] gate_dir,
   input  logic [NUM_GATES-1:0] gate_uni,
   input  logic                 uni_space_avail,
   input  logic                 gen_space_avail,
   input  logic                 uni_parked_nz,
   input  logic                 gen_parked_nz,
   output logic                 car_entered,
   output logic                 car_exited,
   output logic                 is_uni,
   output logic [NUM_GATES-1:0] gate_ack,
   output logic                 gate_ok,
   output logic [NUM_GATES-1:0] barrier_open,
   output logic                 busy
);
   localparam int IDX_W = $clog2(NUM_GATES);
   localparam int TMR_W = $clog2(OPEN_CYCLES + 1);
   localparam logic [IDX_W:0] NG = (IDX_W + 1)'(NUM_GATES);

   typedef enum logic [1:0] {IDLE, DECIDE, OPEN} state_t;

   state_t state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt, gsel, gsel_nxt;
   logic ldir, ldir_nxt, luni, luni_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic ent_nxt, ext_nxt, uni_nxt, ok_nxt, busy_nxt;
   logic [NUM_GATES-1:0] ack_nxt, bar_nxt;
   logic [IDX_W:0] pick;
   logic accept;

   // Returns {found, index} of the first set mask bit at or after base, wrapping.
   function automatic logic [IDX_W:0] rr_pick(input logic [NUM_GATES-1:0] mask,
                                              input logic [IDX_W-1:0] base);
      logic [IDX_W:0] res;
      logic [IDX_W:0] sum;
      res = '0;
      for (int i = NUM_GATES - 1; i >= 0; i--) begin
         sum = {1'b0, base} + (IDX_W + 1)'(i);
         if (sum >= NG) sum = sum - NG;
         if (mask[sum[IDX_W-1:0]]) res = {1'b1, sum[IDX_W-1:0]};
      end
      return res;
   endfunction

   always_comb begin
`ifdef PARKING_EXIT_PRIORITY_EN
      logic [IDX_W:0] exit_pick;
      exit_pick = rr_pick(gate_req & gate_dir, ptr);
      pick = exit_pick[IDX_W] ? exit_pick : rr_pick(gate_req, ptr);
`else
      pick = rr_pick(gate_req, ptr);
`endif
   end

   assign accept = ldir ? (luni ? uni_parked_nz : gen_parked_nz)
                        : (luni ? uni_space_avail : gen_space_avail);

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      gsel_nxt  = gsel;
      ldir_nxt  = ldir;
      luni_nxt  = luni;
      timer_nxt = timer;
      ent_nxt   = 1'b0;
      ext_nxt   = 1'b0;
      uni_nxt   = 1'b0;
      ok_nxt    = 1'b0;
      ack_nxt   = '0;
      bar_nxt   = '0;
      case (state)
         IDLE: begin
            if (pick[IDX_W]) begin
               gsel_nxt  = pick[IDX_W-1:0];
               ldir_nxt  = gate_dir[pick[IDX_W-1:0]];
               luni_nxt  = gate_uni[pick[IDX_W-1:0]];
               state_nxt = DECIDE;
            end
         end
         DECIDE: begin
            // A withdrawn request leaves the pointer alone so the gate keeps its turn.
            if (!gate_req[gsel]) begin
               state_nxt = IDLE;
            end else begin
               ack_nxt[gsel] = 1'b1;
               ptr_nxt = (gsel == IDX_W'(NUM_GATES - 1)) ? '0 : gsel + 1'b1;
               if (accept) begin
                  ok_nxt        = 1'b1;
                  ent_nxt       = !ldir;
                  ext_nxt       = ldir;
                  uni_nxt       = luni;
                  bar_nxt[gsel] = 1'b1;
                  timer_nxt     = TMR_W'(OPEN_CYCLES);
                  state_nxt     = OPEN;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         OPEN: begin
            if (timer <= TMR_W'(1)) begin
               timer_nxt = '0;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer - 1'b1;
               bar_nxt   = barrier_open;
            end
         end
         default: state_nxt = IDLE;
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         ptr          <= '0;
         gsel         <= '0;
         ldir         <= 1'b0;
         luni         <= 1'b0;
         timer        <= '0;
         car_entered  <= 1'b0;
         car_exited   <= 1'b0;
         is_uni       <= 1'b0;
         gate_ack     <= '0;
         gate_ok      <= 1'b0;
         barrier_open <= '0;
         busy         <= 1'b0;
      end else begin
         state        <= state_nxt;
         ptr          <= ptr_nxt;
         gsel         <= gsel_nxt;
         ldir         <= ldir_nxt;
         luni         <= luni_nxt;
         timer        <= timer_nxt;
         car_entered  <= ent_nxt;
         car_exited   <= ext_nxt;
         is_uni       <= uni_nxt;
         gate_ack     <= ack_nxt;
         gate_ok      <= ok_nxt;
         barrier_open <= bar_nxt;
         busy         <= busy_nxt;
      end
   end
endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Bench for parking_gate_arbiter: directed scenarios plus randomized traffic against a timeline model.
module tb_parking_gate_arbiter;
   localparam int N  = 4;
   localparam int OC = 8;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] req, dir, uni;
   logic usa, gsa, upn, gpn;
   logic ent, ext, isu, ok, busy;
   logic [N-1:0] ack, bar;

   int checks = 0;
   int errors = 0;

   parking_gate_arbiter #(.NUM_GATES(N), .OPEN_CYCLES(OC)) dut (
      .clk(clk), .rst(rst), .gate_req(req), .gate_dir(dir), .gate_uni(uni),
      .uni_space_avail(usa), .gen_space_avail(gsa),
      .uni_parked_nz(upn), .gen_parked_nz(gpn),
      .car_entered(ent), .car_exited(ext), .is_uni(isu),
      .gate_ack(ack), .gate_ok(ok), .barrier_open(bar), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; dir = '0; uni = '0;
      usa = 1'b1; gsa = 1'b1; upn = 1'b1; gpn = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 4'b1111; dir = 4'b0101; uni = 4'b0011;
      usa = 1'b1; gsa = 1'b1; upn = 1'b1; gpn = 1'b1;
      tick();
      checks++;
      if ({ent, ext, isu, ack, ok, bar, busy} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 0", {ent, ext, isu, ack, ok, bar, busy});
      end
      req = '0;
      rst = 1'b0;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle_busy: got %b required 0", busy);
      end
   endtask

   task automatic test_accept_entry();
      do_reset();
      req = 4'b0001; dir = 4'b0000; uni = 4'b0000; gsa = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b1 || ack !== 4'b0000) begin
         errors++;
         $display("FAIL accept_decide: busy=%b ack=%b required busy=1 ack=0000", busy, ack);
      end
      tick();
      checks++;
      if ({ent, ext, isu, ack, ok, bar} !== {3'b100, 4'b0001, 1'b1, 4'b0001}) begin
         errors++;
         $display("FAIL accept_strobe: ent=%b ext=%b uni=%b ack=%b ok=%b bar=%b required 1 0 0 0001 1 0001",
                  ent, ext, isu, ack, ok, bar);
      end
      req = '0;
      for (int k = 3; k <= 9; k++) begin
         tick();
         checks++;
         if (bar !== 4'b0001 || ent !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL accept_open_N+%0d: bar=%b ent=%b ack=%b busy=%b required 0001 0 0000 1",
                     k, bar, ent, ack, busy);
         end
      end
      tick();
      checks++;
      if (bar !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL accept_close: bar=%b busy=%b required 0000 0", bar, busy);
      end
   endtask

   task automatic test_deny_exit();
      do_reset();
      req = 4'b0100; dir = 4'b0100; uni = 4'b0100; upn = 1'b0;
      tick();
      tick();
      checks++;
      if ({ack, ok, ext, ent, bar} !== {4'b0100, 1'b0, 1'b0, 1'b0, 4'b0000}) begin
         errors++;
         $display("FAIL deny_ack: ack=%b ok=%b ext=%b ent=%b bar=%b required 0100 0 0 0 0000",
                  ack, ok, ext, ent, bar);
      end
      req = '0;
      tick();
      checks++;
      if (busy !== 1'b0 || ack !== 4'b0000 || bar !== 4'b0000) begin
         errors++;
         $display("FAIL deny_idle: busy=%b ack=%b bar=%b required 0 0000 0000", busy, ack, bar);
      end
   endtask

   task automatic test_round_robin();
      int order [4] = '{0, 1, 3, 0};
      int t;
      do_reset();
      req = 4'b1011; dir = '0; uni = '0;
      for (int k = 0; k < 4; k++) begin
         t = 0;
         while (ack === 4'b0000 && t < 40) begin
            tick();
            t++;
         end
         checks++;
         if (ack !== (4'b0001 << order[k])) begin
            errors++;
            $display("FAIL rr_order_%0d: ack=%b required gate %0d", k, ack, order[k]);
         end
         req[order[k]] = 1'b0;
         tick();
         if (k == 0) req[0] = 1'b1;
      end
   endtask

   task automatic test_withdraw();
      do_reset();
      req = 4'b0001; dir = '0; uni = '0; gsa = 1'b0;
      tick();
      tick();
      checks++;
      if (ack !== 4'b0001 || ok !== 1'b0) begin
         errors++;
         $display("FAIL withdraw_setup: ack=%b ok=%b required 0001 0", ack, ok);
      end
      req = 4'b0010; gsa = 1'b1;
      tick();
      req = 4'b0000;
      tick();
      checks++;
      if (ack !== 4'b0000 || ent !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL withdraw_none: ack=%b ent=%b busy=%b required 0000 0 0", ack, ent, busy);
      end
      req = 4'b0011;
      tick();
      tick();
      checks++;
      if (ack !== 4'b0010) begin
         errors++;
         $display("FAIL withdraw_ptr: ack=%b required 0010", ack);
      end
      req = '0;
   endtask

   task automatic test_reset_mid_open();
      do_reset();
      req = 4'b0100; dir = '0; uni = 4'b0100; usa = 1'b1;
      tick();
      tick();
      req = '0;
      tick();
      tick();
      checks++;
      if (bar !== 4'b0100 || busy !== 1'b1) begin
         errors++;
         $display("FAIL midrst_open: bar=%b busy=%b required 0100 1", bar, busy);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({ent, ext, isu, ack, ok, bar, busy} !== 13'd0) begin
         errors++;
         $display("FAIL midrst_clear: got %b required 0", {ent, ext, isu, ack, ok, bar, busy});
      end
      req = 4'b0001;
      tick();
      tick();
      checks++;
      if (ack !== 4'b0001 || ok !== 1'b1) begin
         errors++;
         $display("FAIL midrst_idle: ack=%b ok=%b required 0001 1", ack, ok);
      end
      req = '0;
   endtask

   task automatic test_priority();
      logic [N-1:0] want;
`ifdef PARKING_EXIT_PRIORITY_EN
      want = 4'b1000;
`else
      want = 4'b0001;
`endif
      do_reset();
      req = 4'b1001; dir = 4'b1000; uni = '0;
      tick();
      tick();
      checks++;
      if (ack !== want) begin
         errors++;
         $display("FAIL priority_first: ack=%b required %b", ack, want);
      end
      req = '0;
   endtask

   // Model gate choice: first requester at/after ptr, exits first when prioritised.
   function automatic int model_pick(logic [N-1:0] r, logic [N-1:0] d, int p);
      int g;
`ifdef PARKING_EXIT_PRIORITY_EN
      for (int i = 0; i < N; i++) begin
         g = (p + i) % N;
         if (r[g] && d[g]) return g;
      end
`endif
      for (int i = 0; i < N; i++) begin
         g = (p + i) % N;
         if (r[g]) return g;
      end
      return -1;
   endfunction

   task automatic test_random();
      int c, m_ptr, m_free, m_g, m_dir, m_uni, bar_g, bar_end;
      logic [12:0] expv, got;
      logic e_ent, e_ext, e_uni, e_ok, e_busy, acc;
      logic [N-1:0] e_ack, e_bar;
      do_reset();
      c = 0; m_ptr = 0; m_free = 0; m_g = -1; m_dir = 0; m_uni = 0; bar_g = 0; bar_end = -1;
      e_ent = 0; e_ext = 0; e_uni = 0; e_ok = 0; e_busy = 0; e_ack = '0; e_bar = '0;
      for (int it = 0; it < 3000; it++) begin
         if (it > 0) begin
            tick();
            c++;
            got  = {ent, ext, isu, ack, ok, bar, busy};
            expv = {e_ent, e_ext, e_uni, e_ack, e_ok, e_bar, e_busy};
            checks++;
            if (got !== expv) begin
               errors++;
               $display("FAIL random_cycle_%0d: got %b required %b (ent ext uni ack ok bar busy)",
                        c, got, expv);
            end
         end
         rst = ($urandom_range(0, 199) == 0);
         for (int g = 0; g < N; g++) begin
            if (req[g]) begin
               if (e_ack[g] || $urandom_range(0, 19) == 0) req[g] = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
               req[g] = 1'b1;
               dir[g] = $urandom_range(0, 1);
               uni[g] = $urandom_range(0, 1);
            end
         end
         usa = ($urandom_range(0, 3) != 0);
         gsa = ($urandom_range(0, 3) != 0);
         upn = ($urandom_range(0, 3) != 0);
         gpn = ($urandom_range(0, 3) != 0);
         e_ent = 0; e_ext = 0; e_uni = 0; e_ok = 0; e_ack = '0;
         if (rst) begin
            m_ptr = 0; m_g = -1; m_free = c + 1; bar_end = -1;
         end else if (m_g >= 0) begin
            if (!req[m_g]) begin
               m_free = c + 1;
            end else begin
               acc = m_dir ? (m_uni ? upn : gpn) : (m_uni ? usa : gsa);
               e_ack[m_g] = 1'b1;
               e_ok = acc;
               m_ptr = (m_g + 1) % N;
               if (acc) begin
                  e_ent = !m_dir[0]; e_ext = m_dir[0]; e_uni = m_uni[0];
                  bar_g = m_g; bar_end = c + OC; m_free = c + 1 + OC;
               end else begin
                  m_free = c + 1;
               end
            end
            m_g = -1;
         end else if (c >= m_free) begin
            m_g = model_pick(req, dir, m_ptr);
            if (m_g >= 0) begin
               m_dir = int'(dir[m_g]); m_uni = int'(uni[m_g]);
            end
         end
         e_bar = (c + 1 <= bar_end) ? (4'b0001 << bar_g) : 4'b0000;
         e_busy = (m_g >= 0) || (c + 1 < m_free);
      end
      rst = 1'b0;
      req = '0;
   endtask

   initial begin
      test_reset();
      test_accept_entry();
      test_deny_exit();
      test_round_robin();
      test_withdraw();
      test_reset_mid_open();
      test_priority();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
